mem_stage: RTL

Memory-access pipeline stage of the 5-stage core, between EXU and write-back. Registers the EX result, runs load/store transactions on a valid/grant/rvalid data bus, formats load data, and feeds WB. Publishes the M-stage destination (`o_rdidx_mem`, `o_rdwen_mem`, `o_ld_mem`) to the hazard controller for forwarding and load-use detection. Raises `o_stall_mem` so the hazard controller can hold F/D/E while a bus transaction is outstanding.

---
 rtl/core_pkg.sv | 27 ++
 rtl/ld_fmt.sv | 44 ++++
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg                                                             |
// | Shared funct3 encodings and memory-stage FSM states.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_t;

    // Encodings with no defined access size.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ld_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ld_fmt                                                               |
// | Load lane selection with sign or zero extension.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ld_fmt
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage                                                            |
// | M pipeline stage: data-bus load/store, load formatting, WB register. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid_e,
    input  logic [XLEN-1:0] i_alu_res_e,
    input  logic [XLEN-1:0] i_wdata_e,
    input  logic [4:0]      i_rdidx_e,
    input  logic            i_rdwen_e,
    input  logic            i_ld_e,
    input  logic            i_st_e,
    input  logic [2:0]      i_funct3_e,
    output logic [4:0]      o_rdidx_mem,
    output logic            o_rdwen_mem,
    output logic            o_ld_mem,
    output logic [XLEN-1:0] o_fwd_data_mem,
    output logic            o_stall_mem,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [XLEN-1:0] o_dbus_addr,
    output logic [XLEN-1:0] o_dbus_wdata,
    output logic [3:0]      o_dbus_be,
    input  logic            i_dbus_gnt,
    input  logic            i_dbus_rvalid,
    input  logic [XLEN-1:0] i_dbus_rdata,
    output logic            o_valid_wb,
    output logic [4:0]      o_rdidx_wb,
    output logic            o_rdwen_wb,
    output logic [XLEN-1:0] o_wbdata_wb,
    output logic            o_misalign
);

    logic            r_m_valid;
    logic [XLEN-1:0] r_m_alu;
    logic [XLEN-1:0] r_m_wdata;
    logic [4:0]      r_m_rdidx;
    logic            r_m_rdwen;
    logic            r_m_ld;
    logic            r_m_st;
    logic [2:0]      r_m_funct3;

    logic            r_valid_wb;
    logic [4:0]      r_rdidx_wb;
    logic            r_rdwen_wb;
    logic [XLEN-1:0] r_wbdata_wb;

    mem_state_t      r_state;
    mem_state_t      w_state_nxt;

    logic [1:0]      w_a;
    logic            w_mem_op;
    logic            w_misalign;
    logic            w_issue;
    logic            w_done;
    logic            w_req;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_st_data;
    logic [XLEN-1:0] w_ld_data;

    assign w_a      = r_m_alu[1:0];
    assign w_mem_op = r_m_valid & (r_m_ld | r_m_st);

    always_comb begin
        w_misalign = f3_illegal(r_m_funct3);
        case (r_m_funct3[1:0])
            2'b01:   if (w_a[0])        w_misalign = 1'b1;
            2'b10:   if (w_a != 2'b00)  w_misalign = 1'b1;
            default: ;
        endcase
    end

    assign w_issue     = w_mem_op & ~w_misalign;
    assign w_done      = (r_state == MEM_WAIT) & i_dbus_rvalid;
    // Dropping stall in the response cycle lets the next instruction enter M on the same edge.
    assign o_stall_mem = w_issue & ~w_done;
    assign o_misalign  = w_mem_op & w_misalign;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (w_issue) begin
                    w_req       = 1'b1;
                    w_state_nxt = i_dbus_gnt ? MEM_WAIT : MEM_REQ;
                end
            end
            MEM_REQ: begin
                w_req = 1'b1;
                if (i_dbus_gnt) w_state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (i_dbus_rvalid) w_state_nxt = MEM_IDLE;
            end
            default: w_state_nxt = MEM_IDLE;
        endcase
    end

    always_comb begin
        w_be      = 4'b1111;
        w_st_data = r_m_wdata;
        case (r_m_funct3[1:0])
            2'b00: begin
                w_be      = 4'b0001 << w_a;
                w_st_data = {4{r_m_wdata[7:0]}};
            end
            2'b01: begin
                w_be      = 4'b0011 << {w_a[1], 1'b0};
                w_st_data = {2{r_m_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Bus fields come straight from the held M register, so they stay stable until grant.
    assign o_dbus_req   = w_req;
    assign o_dbus_we    = w_req & r_m_st;
    assign o_dbus_addr  = w_req ? {r_m_alu[XLEN-1:2], 2'b00} : '0;
    assign o_dbus_wdata = w_req ? w_st_data : '0;
    assign o_dbus_be    = w_req ? w_be : 4'b0000;

    ld_fmt #(
        .XLEN (XLEN)
    ) u_ld_fmt (
        .i_funct3 (r_m_funct3),
        .i_addr   (w_a),
        .i_rdata  (i_dbus_rdata),
        .o_data   (w_ld_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m_valid  <= 1'b0;
            r_m_alu    <= '0;
            r_m_wdata  <= '0;
            r_m_rdidx  <= 5'd0;
            r_m_rdwen  <= 1'b0;
            r_m_ld     <= 1'b0;
            r_m_st     <= 1'b0;
            r_m_funct3 <= 3'd0;
        end else if (!o_stall_mem) begin
            r_m_valid  <= i_valid_e;
            r_m_alu    <= i_alu_res_e;
            r_m_wdata  <= i_wdata_e;
            r_m_rdidx  <= i_rdidx_e;
            r_m_rdwen  <= i_rdwen_e;
            r_m_ld     <= i_ld_e;
            r_m_st     <= i_st_e;
            r_m_funct3 <= i_funct3_e;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid_wb  <= 1'b0;
            r_rdidx_wb  <= 5'd0;
            r_rdwen_wb  <= 1'b0;
            r_wbdata_wb <= '0;
        end else if (o_stall_mem) begin
            r_valid_wb <= 1'b0;
            r_rdwen_wb <= 1'b0;
        end else begin
            r_valid_wb  <= r_m_valid;
            r_rdidx_wb  <= r_m_rdidx;
            r_rdwen_wb  <= r_m_valid & r_m_rdwen & ~o_misalign;
            r_wbdata_wb <= (r_m_ld & w_issue) ? w_ld_data : r_m_alu;
        end
    end

    assign o_rdidx_mem    = r_m_rdidx;
    assign o_rdwen_mem    = r_m_valid & r_m_rdwen;
    assign o_ld_mem       = r_m_valid & r_m_ld;
    assign o_fwd_data_mem = r_m_alu;

    assign o_valid_wb  = r_valid_wb;
    assign o_rdidx_wb  = r_rdidx_wb;
    assign o_rdwen_wb  = r_rdwen_wb;
    assign o_wbdata_wb = r_wbdata_wb;

endmodule
`default_nettype wire
